// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded arbiter sharing one FIFO write port
// among NUM_REQ producers, with back-pressure on fifo_full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int data_width = 32,
    parameter int MAX_BURST  = 4,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*data_width-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_cs,
    output logic                          fifo_wr_ena,
    output logic [data_width-1:0]         fifo_data_in,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t          state, state_nxt;
    logic [IW-1:0]   owner, owner_nxt, last_owner, last_nxt, pick, idx;
    logic [BW-1:0]   burst_cnt, cnt_nxt;
    logic            xfer;
    // Scan downward so the nearest requester after last_owner wins; last_owner itself is checked last.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_owner) + k) % NUM_REQ);
            if (req_valid[idx]) pick = idx;
        end
    end
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        last_nxt     = last_owner;
        cnt_nxt      = burst_cnt;
        busy         = (state == BURST);
        fifo_cs      = busy;
        xfer         = busy && req_valid[owner] && !fifo_full;
        fifo_wr_ena  = xfer;
        req_ready    = xfer ? (NUM_REQ'(1) << owner) : '0;
        fifo_data_in = busy ? req_data[int'(owner)*data_width +: data_width] : '0;
        grant_id     = owner;
        if (state == IDLE) begin
            if (|req_valid) begin
                state_nxt = BURST;
                owner_nxt = pick;
                last_nxt  = pick;
                cnt_nxt   = '0;
            end
        end else if (xfer) begin
            state_nxt = (burst_cnt == BW'(MAX_BURST - 1)) ? IDLE : BURST;
            cnt_nxt   = (burst_cnt == BW'(MAX_BURST - 1)) ? burst_cnt : burst_cnt + 1'b1;
        end else if (!req_valid[owner]) begin
            state_nxt = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_nxt;
            burst_cnt  <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenario tests for fifo_wr_arbiter with a small
// producer and FIFO model driving the DUT.
module tb_fifo_wr_arbiter;
    localparam int N = 4, DW = 32, MB = 4;
    logic clk = 1'b0, rst = 1'b0;
    logic [N-1:0] req_valid, req_ready;
    logic [N*DW-1:0] req_data;
    logic fifo_full, fifo_cs, fifo_wr_ena, busy;
    logic [DW-1:0] fifo_data_in;
    logic [1:0] grant_id;
    int vecs = 0, errs = 0;
    logic [DW-1:0] pw [N][16];
    int plen [N], pidx [N];
    bit pen [N];
    bit mh;
    logic [DW-1:0] wlog [$], fq [$];
    logic [1:0] glog [$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(N), .data_width(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_cs(fifo_cs),
        .fifo_wr_ena(fifo_wr_ena), .fifo_data_in(fifo_data_in),
        .grant_id(grant_id), .busy(busy)
    );

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pen[i] && (pidx[i] < plen[i]);
            req_data[i*DW +: DW] = (pidx[i] < plen[i]) ? pw[i][pidx[i]] : '0;
        end
    endtask

    // One clock: log writes at negedge, advance producers/FIFO just after posedge.
    task automatic step(input bit rd);
        logic [N-1:0] acc;
        @(negedge clk);
        if (fifo_cs && fifo_wr_ena) begin
            wlog.push_back(fifo_data_in);
            glog.push_back(grant_id);
            fq.push_back(fifo_data_in);
        end
        if (!$onehot0(req_ready)) mh = 1'b1;
        acc = req_ready;
        if (rd && fq.size() > 0) void'(fq.pop_front());
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) pidx[i]++;
        drive();
        fifo_full = (fq.size() >= 8);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            pen[i] = 1'b0; plen[i] = 0; pidx[i] = 0;
        end
        drive();
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wlog.delete(); glog.delete(); fq.delete();
        mh = 1'b0;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            pen[i] = 1'b1; plen[i] = 1; pidx[i] = 0; pw[i][0] = 32'hC0 + i;
        end
        drive();
        fifo_full = 1'b0;
        #1;
        vecs++; if (req_ready !== 4'b0) begin errs++; $display("FAIL rst_ready got %b want 0000", req_ready); end
        vecs++; if (fifo_cs !== 1'b0) begin errs++; $display("FAIL rst_cs got %b want 0", fifo_cs); end
        vecs++; if (fifo_wr_ena !== 1'b0) begin errs++; $display("FAIL rst_wr got %b want 0", fifo_wr_ena); end
        vecs++; if (fifo_data_in !== 32'h0) begin errs++; $display("FAIL rst_data got %h want 0", fifo_data_in); end
        vecs++; if (grant_id !== 2'd0) begin errs++; $display("FAIL rst_gid got %0d want 0", grant_id); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got %b want 0", busy); end
        step(1'b0); step(1'b0);
        vecs++; if (wlog.size() !== 0) begin errs++; $display("FAIL rst_nowrite got %0d want 0", wlog.size()); end
        rst = 1'b1;
        #1;
        vecs++; if (busy !== 1'b0 || fifo_wr_ena !== 1'b0) begin errs++; $display("FAIL arb_cycle got busy=%b wr=%b want 0 0", busy, fifo_wr_ena); end
        step(1'b0);
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL first_busy got %b want 1", busy); end
        vecs++; if (grant_id !== 2'd0) begin errs++; $display("FAIL first_gid got %0d want 0", grant_id); end
        vecs++; if (fifo_data_in !== 32'hC0) begin errs++; $display("FAIL first_data got %h want c0", fifo_data_in); end
    endtask

    task automatic test_single();
        logic [9:0] pat;
        do_reset();
        for (int k = 0; k < 5; k++) pw[0][k] = 32'h11 * (k + 1);
        plen[0] = 5; pen[0] = 1'b1;
        drive();
        #1;
        for (int k = 0; k < 10; k++) begin
            pat[9-k] = fifo_wr_ena;
            step(1'b0);
        end
        vecs++; if (pat !== 10'b0111101000) begin errs++; $display("FAIL single_pattern got %b want 0111101000", pat); end
        vecs++; if (wlog.size() !== 5) begin errs++; $display("FAIL single_count got %0d want 5", wlog.size()); end
        for (int j = 0; j < 5 && j < wlog.size(); j++) begin
            vecs++; if (wlog[j] !== 32'h11 * (j + 1)) begin errs++; $display("FAIL single_word%0d got %h want %h", j, wlog[j], 32'h11 * (j + 1)); end
            vecs++; if (glog[j] !== 2'd0) begin errs++; $display("FAIL single_gid%0d got %0d want 0", j, glog[j]); end
        end
    endtask

    task automatic test_round_robin();
        int b;
        logic [1:0] own;
        logic [31:0] expw;
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 16; k++) pw[i][k] = 32'hA0 + 16 * k + i;
            plen[i] = 16; pen[i] = 1'b1;
        end
        drive();
        #1;
        repeat (26) step(1'b1);
        vecs++; if (wlog.size() !== 20) begin errs++; $display("FAIL rr_count got %0d want 20", wlog.size()); end
        for (int j = 0; j < 20 && j < wlog.size(); j++) begin
            b = j / 4;
            own = 2'(b % 4);
            expw = 32'hA0 + 16 * ((b / 4) * 4 + j % 4) + own;
            vecs++; if (glog[j] !== own) begin errs++; $display("FAIL rr_gid%0d got %0d want %0d", j, glog[j], own); end
            vecs++; if (wlog[j] !== expw) begin errs++; $display("FAIL rr_word%0d got %h want %h", j, wlog[j], expw); end
        end
        vecs++; if (mh !== 1'b0) begin errs++; $display("FAIL rr_onehot got multihot=%b want 0", mh); end
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int k = 0; k < 8; k++) fq.push_back(32'h5000 + k);
        fifo_full = 1'b1;
        pw[2][0] = 32'hDEADBEEF; plen[2] = 1; pen[2] = 1'b1;
        drive();
        #1;
        step(1'b0);
        for (int k = 0; k < 3; k++) begin
            vecs++; if (fifo_wr_ena !== 1'b0 || req_ready !== 4'b0) begin errs++; $display("FAIL full_stall%0d got wr=%b ready=%b want 0 0000", k, fifo_wr_ena, req_ready); end
            vecs++; if (grant_id !== 2'd2 || busy !== 1'b1) begin errs++; $display("FAIL full_gid%0d got gid=%0d busy=%b want 2 1", k, grant_id, busy); end
            step(k == 2);
        end
        vecs++; if (fifo_wr_ena !== 1'b1 || req_ready !== 4'b0100) begin errs++; $display("FAIL full_resume got wr=%b ready=%b want 1 0100", fifo_wr_ena, req_ready); end
        vecs++; if (fifo_data_in !== 32'hDEADBEEF) begin errs++; $display("FAIL full_data got %h want deadbeef", fifo_data_in); end
        step(1'b0);
        step(1'b0);
        vecs++; if (wlog.size() !== 1 || wlog[0] !== 32'hDEADBEEF) begin errs++; $display("FAIL full_written got n=%0d w=%h want 1 deadbeef", wlog.size(), wlog.size() > 0 ? wlog[0] : 32'h0); end
    endtask

    task automatic test_early_release();
        logic [31:0] ew [5] = '{32'h1001, 32'h1002, 32'h3001, 32'h3002, 32'h1003};
        logic [1:0]  eg [5] = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1};
        do_reset();
        pw[1][0] = 32'h1001; pw[1][1] = 32'h1002; pw[1][2] = 32'h1003; plen[1] = 2; pen[1] = 1'b1;
        pw[3][0] = 32'h3001; pw[3][1] = 32'h3002; plen[3] = 2; pen[3] = 1'b1;
        drive();
        #1;
        repeat (3) step(1'b0);
        vecs++; if (busy !== 1'b1 || fifo_wr_ena !== 1'b0) begin errs++; $display("FAIL early_drop got busy=%b wr=%b want 1 0", busy, fifo_wr_ena); end
        step(1'b0);
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL early_idle got %b want 0", busy); end
        plen[1] = 3;
        drive();
        #1;
        repeat (8) step(1'b0);
        vecs++; if (wlog.size() !== 5) begin errs++; $display("FAIL early_count got %0d want 5", wlog.size()); end
        for (int j = 0; j < 5 && j < wlog.size(); j++) begin
            vecs++; if (wlog[j] !== ew[j] || glog[j] !== eg[j]) begin errs++; $display("FAIL early_word%0d got %h/%0d want %h/%0d", j, wlog[j], glog[j], ew[j], eg[j]); end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 4; k++) pw[0][k] = 32'h51 + k;
        plen[0] = 4; pen[0] = 1'b1;
        drive();
        #1;
        step(1'b0); step(1'b0);
        vecs++; if (fifo_wr_ena !== 1'b1 || fifo_data_in !== 32'h52) begin errs++; $display("FAIL mid_pre got wr=%b data=%h want 1 52", fifo_wr_ena, fifo_data_in); end
        rst = 1'b0;
        #1;
        vecs++; if (fifo_wr_ena !== 1'b0 || req_ready !== 4'b0) begin errs++; $display("FAIL mid_drop got wr=%b ready=%b want 0 0000", fifo_wr_ena, req_ready); end
        vecs++; if (busy !== 1'b0 || fifo_cs !== 1'b0 || fifo_data_in !== 32'h0) begin errs++; $display("FAIL mid_outs got busy=%b cs=%b data=%h want 0 0 0", busy, fifo_cs, fifo_data_in); end
        pw[1][0] = 32'h61; plen[1] = 1; pen[1] = 1'b1;
        drive();
        step(1'b0);
        vecs++; if (wlog.size() !== 1) begin errs++; $display("FAIL mid_nowrite got %0d want 1", wlog.size()); end
        rst = 1'b1;
        #1;
        step(1'b0);
        vecs++; if (grant_id !== 2'd0 || busy !== 1'b1) begin errs++; $display("FAIL mid_prio got gid=%0d busy=%b want 0 1", grant_id, busy); end
        vecs++; if (fifo_data_in !== 32'h52) begin errs++; $display("FAIL mid_resume got %h want 52", fifo_data_in); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_early_release();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of one synchronous_FIFO instance between NUM_REQ independent producers.
- Round-robin grant with bounded bursts; drives the FIFO's cs, wr_ena and data_in, and back-pressures producers on full.
- Sits directly in front of the FIFO; the read side is untouched.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- data_width, 32: word width; must match the FIFO's data_width.
- MAX_BURST, 4: maximum words written per grant before rotating (1..16).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester word-valid.
- req_data  input  NUM_REQ*data_width  packed words; requester i occupies bits [i*data_width +: data_width].
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- fifo_full  input  1  FIFO full flag.
- fifo_cs  output  1  FIFO chip select.
- fifo_wr_ena  output  1  FIFO write enable.
- fifo_data_in  output  data_width  word to FIFO.
- grant_id  output  clog2(NUM_REQ), min 1  current/last owner index.
- busy  output  1  high while a grant is held.

Behaviour:
- Reset (rst low, async): state=IDLE, owner=0, last_owner=NUM_REQ-1 (requester 0 has first priority), burst_cnt=0. Outputs: req_ready=0, fifo_cs=0, fifo_wr_ena=0, fifo_data_in=0, grant_id=0, busy=0. Outputs are decoded from state, so they drop in the same instant rst asserts. A word presented during reset is not written.
- FSM states: IDLE, BURST.
- IDLE: no outputs active. On a clock edge with any req_valid high, owner = first i with req_valid[i]=1, searching from (last_owner+1) mod NUM_REQ upward with wrap. Then last_owner=owner, burst_cnt=0, go to BURST. Arbitration latency is 1 cycle; no word is accepted in the arbitration cycle.
- BURST, combinational outputs:
  - fifo_cs=1, busy=1, grant_id=owner, fifo_data_in=req_data slice of owner.
  - xfer = req_valid[owner] & ~fifo_full.
  - fifo_wr_ena = req_ready[owner] = xfer; all other req_ready bits are 0.
- BURST, transfer: a transfer occurs on an edge where xfer=1, and the FIFO captures the word on that same edge.
  - On a transfer with burst_cnt==MAX_BURST-1: go to IDLE.
  - On any other transfer: burst_cnt+1.
- BURST, no transfer:
  - req_valid[owner]=0: go to IDLE. The grant is released even mid-burst.
  - fifo_full=1 with valid high: stall. Grant held, burst_cnt unchanged, nothing written, no timeout.
- After returning to IDLE, at least one idle cycle separates bursts. The owner that just finished has lowest priority in the next arbitration.
- Other requesters' valids never affect the current burst.
- Producers must hold req_valid and data stable until ready; the arbiter does not check this.
- fifo_full deassert mid-burst resumes writing on the next edge with xfer=1, with no lost or duplicated words.
- No combinational path from fifo_full to any state update except through xfer.

Test Plan:
- Reset: hold rst=0 with all req_valid=1, then check all outputs are 0. Release rst. The first grant goes to requester 0 after 1 cycle; grant_id=0.
- Single producer: req0 streams 0x11,0x22,0x33,0x44,0x55 with others idle. Expect 4 words written back-to-back, then 1 idle cycle, re-grant to req0, 0x55 written. FIFO read-back order is 0x11..0x55.
- Round robin: all 4 requesters hold valid with data 0xA0+n, 0xB0+n, ... (n = requester index). Expect grant order 0,1,2,3,0 and exactly MAX_BURST=4 words per grant. req_ready is never multi-hot.
- Full stall: fill the FIFO to 8 words, then req2 asserts valid with 0xDEADBEEF. Expect fifo_wr_ena=0 and req_ready=0 while full; grant_id stays 2. Read one word, and 0xDEADBEEF is written on the next edge.
- Early release: req1 writes 2 words then drops valid, with req3 valid. Expect BURST→IDLE, then grant to req3 with no third req1 word written.
- Mid-burst reset: assert rst low during the 2nd word of a burst. Expect outputs 0 immediately and no write on that edge. After release, priority restarts at requester 0.
